// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered DATA_WIDTH-bit ALU with a start/done handshake. add, sub, nand,
//   nor, and, xor and the reserved opcode finish one edge after the start edge.
//   Multiply is a shift-add sequence that folds in one partial product per
//   clock, so its result appears DATA_WIDTH+1 edges after the start edge.
//
//   Optional build macro: ALU_SEQ_FLAGS_EN adds the zero/cout/illegal outputs.
//
//   Ports
//     clk_in       in   clock, rising edge
//     rst_in       in   asynchronous reset, active high
//     start_in     in   start request, only looked at while busy_out=0
//     a_in, b_in   in   operands, latched on an accepted start
//     sel_in       in   opcode, latched on an accepted start
//     q_out        out  result (2*DATA_WIDTH), held until the next op completes
//     busy_out     out  high while a multiply is in progress
//     done_out     out  one-cycle pulse when q_out is updated
//     zero_out     out  (ALU_SEQ_FLAGS_EN) result is zero
//     cout_out     out  (ALU_SEQ_FLAGS_EN) add carry / sub borrow / mul overflow
//     illegal_out  out  (ALU_SEQ_FLAGS_EN) reserved opcode 111 was executed
//
//   State  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start; single-cycle ops complete from here
//   S_MUL  | shift-add multiply running, one multiplier bit per edge
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [DATA_WIDTH-1:0]     a_in,
    input  logic [DATA_WIDTH-1:0]     b_in,
    input  logic [2:0]                sel_in,
    output logic [2*DATA_WIDTH-1:0]   q_out,
    output logic                      busy_out,
    output logic                      done_out
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                      zero_out,
    output logic                      cout_out,
    output logic                      illegal_out
`endif
);

    localparam int QW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t                  r_state;
    logic [QW-1:0]           r_q;
    logic                    r_busy;
    logic                    r_done;
    logic [QW-1:0]           r_acc;
    logic [QW-1:0]           r_mcand;   // multiplicand, pre-shifted by the count
    logic [DATA_WIDTH-1:0]   r_mplier;  // multiplier, bit 0 is bit[count]
    logic [CNT_W-1:0]        r_cnt;
`ifdef ALU_SEQ_FLAGS_EN
    logic                    r_zero;
    logic                    r_cout;
    logic                    r_illegal;
`endif

    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [QW-1:0]           w_result;
    logic                    w_cout;
    logic [QW-1:0]           w_acc_next;

    assign w_sum  = {1'b0, a_in} + {1'b0, b_in};
    assign w_diff = {1'b0, a_in} - {1'b0, b_in};

    // Single-cycle results straight from the inputs; only consumed on the
    // accepted start edge, so nothing here reaches an output combinationally.
    always_comb begin
        w_result = '0;
        w_cout   = 1'b0;
        case (sel_in)
            OP_ADD: begin
                w_result = {{(DATA_WIDTH-1){1'b0}}, w_sum};
                w_cout   = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                // borrow fills the whole upper half
                w_result = {{DATA_WIDTH{w_diff[DATA_WIDTH]}}, w_diff[DATA_WIDTH-1:0]};
                w_cout   = w_diff[DATA_WIDTH];
            end
            OP_NAND: w_result = {{DATA_WIDTH{1'b0}}, ~(a_in & b_in)};
            OP_NOR:  w_result = {{DATA_WIDTH{1'b0}}, ~(a_in | b_in)};
            OP_AND:  w_result = {{DATA_WIDTH{1'b0}}, a_in & b_in};
            OP_XOR:  w_result = {{DATA_WIDTH{1'b0}}, a_in ^ b_in};
            default: begin
                w_result = '0;
                w_cout   = 1'b0;
            end
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            r_zero    <= 1'b0;
            r_cout    <= 1'b0;
            r_illegal <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        if (sel_in == OP_MUL) begin
                            r_mcand  <= {{DATA_WIDTH{1'b0}}, a_in};
                            r_mplier <= b_in;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            r_q    <= w_result;
                            r_done <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                            r_zero    <= (w_result == '0);
                            r_cout    <= w_cout;
                            r_illegal <= (sel_in == OP_RSV);
`endif
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_q     <= w_acc_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef ALU_SEQ_FLAGS_EN
                        r_zero    <= (w_acc_next == '0);
                        r_cout    <= |w_acc_next[QW-1:DATA_WIDTH];
                        r_illegal <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign q_out    = r_q;
    assign busy_out = r_busy;
    assign done_out = r_done;
`ifdef ALU_SEQ_FLAGS_EN
    assign zero_out    = r_zero;
    assign cout_out    = r_cout;
    assign illegal_out = r_illegal;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int DW = 8;
    localparam int QW = 2 * DW;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic          clk_in   = 1'b0;
    logic          rst_in   = 1'b0;
    logic          start_in = 1'b0;
    logic [DW-1:0] a_in     = '0;
    logic [DW-1:0] b_in     = '0;
    logic [2:0]    sel_in   = '0;
    logic [QW-1:0] q_out;
    logic          busy_out;
    logic          done_out;
`ifdef ALU_SEQ_FLAGS_EN
    logic          zero_out;
    logic          cout_out;
    logic          illegal_out;
`endif

    int checks = 0;
    int errors = 0;

    alu_seq #(.DATA_WIDTH(DW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .sel_in     (sel_in),
        .q_out      (q_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .zero_out   (zero_out),
        .cout_out   (cout_out),
        .illegal_out(illegal_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference model: plain arithmetic on zero-extended operands.
    function automatic logic [QW-1:0] model_q(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [2:0] sel);
        logic [QW-1:0] ea;
        logic [QW-1:0] eb;
        ea = {{DW{1'b0}}, a};
        eb = {{DW{1'b0}}, b};
        case (sel)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;   // wraps to all-ones upper half when a<b
            3'd2:    return ea * eb;
            3'd3:    return {{DW{1'b0}}, ~(a & b)};
            3'd4:    return {{DW{1'b0}}, ~(a | b)};
            3'd5:    return {{DW{1'b0}}, a & b};
            3'd6:    return {{DW{1'b0}}, a ^ b};
            default: return '0;
        endcase
    endfunction

    function automatic logic model_cout(input logic [DW-1:0] a,
                                        input logic [DW-1:0] b,
                                        input logic [2:0] sel);
        int unsigned ia;
        int unsigned ib;
        ia = int'(a);
        ib = int'(b);
        case (sel)
            3'd0:    return (ia + ib) >= (1 << DW);
            3'd1:    return ia < ib;
            3'd2:    return (ia * ib) >= (1 << DW);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents a start for exactly one rising edge, then
    // scrambles the inputs to show the op in flight does not depend on them.
    task automatic drive_start(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [2:0] sel);
        a_in     = a;
        b_in     = b;
        sel_in   = sel;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        a_in     = DW'($urandom);
        b_in     = DW'($urandom);
        sel_in   = 3'($urandom);
    endtask

    // Issues an op and waits (bounded) for done_out; returns at the negedge
    // of the done cycle so a back-to-back start can be driven from there.
    task automatic run_op(input string tag, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [2:0] sel);
        int edges;
        int busy_cnt;
        edges    = 1;
        busy_cnt = 0;
        drive_start(a, b, sel);
        while (!done_out && edges < 40) begin
            if (busy_out) busy_cnt++;
            @(negedge clk_in);
            edges++;
        end
        check({tag, ".done"}, 64'(done_out), 64'(1'b1));
        check({tag, ".q"}, 64'(q_out), 64'(model_q(a, b, sel)));
        check({tag, ".latency"}, 64'(edges), 64'((sel == OP_MUL) ? DW + 1 : 1));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'((sel == OP_MUL) ? DW : 0));
        check({tag, ".busy_at_done"}, 64'(busy_out), 64'(1'b0));
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, ".zero"}, 64'(zero_out), 64'(model_q(a, b, sel) == '0));
        check({tag, ".cout"}, 64'(cout_out), 64'(model_cout(a, b, sel)));
        check({tag, ".illegal"}, 64'(illegal_out), 64'(sel == OP_RSV));
`endif
    endtask

    task automatic finish_op(input string tag, input logic [QW-1:0] q_exp);
        @(negedge clk_in);
        check({tag, ".done_pulse"}, 64'(done_out), 64'(1'b0));
        check({tag, ".q_hold"}, 64'(q_out), 64'(q_exp));
    endtask

    initial begin
        int edges;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [2:0]    rs;

        // asynchronous reset with no clock edge involved
        #1 rst_in = 1'b1;
        #1;
        check("reset.q", 64'(q_out), 64'(0));
        check("reset.busy", 64'(busy_out), 64'(0));
        check("reset.done", 64'(done_out), 64'(0));
`ifdef ALU_SEQ_FLAGS_EN
        check("reset.flags", 64'({zero_out, cout_out, illegal_out}), 64'(0));
`endif
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        run_op("add200_100", 8'd200, 8'd100, OP_ADD);
        check("add200_100.value", 64'(q_out), 64'(16'h012C));
        finish_op("add200_100", 16'h012C);

        run_op("sub3_5", 8'd3, 8'd5, OP_SUB);
        check("sub3_5.value", 64'(q_out), 64'(16'hFFFE));
        finish_op("sub3_5", 16'hFFFE);
        run_op("sub5_3", 8'd5, 8'd3, OP_SUB);
        check("sub5_3.value", 64'(q_out), 64'(16'h0002));
        finish_op("sub5_3", 16'h0002);

        run_op("mul255", 8'd255, 8'd255, OP_MUL);
        check("mul255.value", 64'(q_out), 64'(16'hFE01));
        finish_op("mul255", 16'hFE01);
        run_op("mul0_77", 8'd0, 8'd77, OP_MUL);
        finish_op("mul0_77", 16'h0000);

        // back-to-back: add accepted in the multiply's done cycle
        run_op("b2b_mul", 8'd17, 8'd29, OP_MUL);
        run_op("b2b_add", 8'd7, 8'd9, OP_ADD);
        check("b2b_add.value", 64'(q_out), 64'(16'h0010));
        finish_op("b2b_add", 16'h0010);

        // start pulsed while busy must be ignored
        drive_start(8'd255, 8'd255, OP_MUL);
        edges = 1;
        @(negedge clk_in);
        edges++;
        drive_start(8'd1, 8'd1, OP_ADD);
        edges++;
        while (!done_out && edges < 40) begin
            @(negedge clk_in);
            edges++;
        end
        check("busy_ignore.latency", 64'(edges), 64'(DW + 1));
        check("busy_ignore.q", 64'(q_out), 64'(16'hFE01));
        finish_op("busy_ignore", 16'hFE01);

        run_op("nand", 8'hF0, 8'hCC, OP_NAND);
        check("nand.value", 64'(q_out), 64'(16'h003F));
        finish_op("nand", 16'h003F);
        run_op("nor", 8'hF0, 8'hCC, OP_NOR);
        check("nor.value", 64'(q_out), 64'(16'h0003));
        finish_op("nor", 16'h0003);
        run_op("xor", 8'hF0, 8'hCC, OP_XOR);
        check("xor.value", 64'(q_out), 64'(16'h003C));
        finish_op("xor", 16'h003C);
        run_op("rsv", 8'hF0, 8'hCC, OP_RSV);
        finish_op("rsv", 16'h0000);

        // reset four edges into a multiply, between clock edges
        run_op("pre_rst_add", 8'd10, 8'd20, OP_ADD);
        finish_op("pre_rst_add", 16'd30);
        drive_start(8'd200, 8'd3, OP_MUL);
        repeat (3) @(negedge clk_in);
        check("mid_mul.busy", 64'(busy_out), 64'(1'b1));
        #2 rst_in = 1'b1;
        #1;
        check("mid_rst.q", 64'(q_out), 64'(0));
        check("mid_rst.busy", 64'(busy_out), 64'(0));
        check("mid_rst.done", 64'(done_out), 64'(0));
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_rst.idle_done", 64'(done_out), 64'(0));
        run_op("mul12_13", 8'd12, 8'd13, OP_MUL);
        check("mul12_13.value", 64'(q_out), 64'(16'h009C));
        finish_op("mul12_13", 16'h009C);

        // randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom_range(0, (1 << DW) - 1));
            rs = 3'($urandom_range(0, 7));
            run_op($sformatf("rand%0d_sel%0d", i, rs), ra, rb, rs);
            finish_op($sformatf("rand%0d", i), model_q(ra, rb, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit gate-level ALU; sits on the datapath between operand registers and the result bus.
- Supports add, sub, nand, nor, and, xor and multiply on DATA_WIDTH-bit operands, with a start/done handshake.
- Multiply is a multi-cycle shift-add sequence, one partial product per clock.
- All other ops complete in one clock.

Parameters:
- DATA_WIDTH, 8, operand width in bits; legal values >= 2; result width is 2*DATA_WIDTH.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- start_in  input  1  start request; sampled only while busy_out=0.
- a_in  input  DATA_WIDTH  operand A; latched on an accepted start.
- b_in  input  DATA_WIDTH  operand B; latched on an accepted start.
- sel_in  input  3  opcode; latched on an accepted start.
- q_out  output  2*DATA_WIDTH  registered result; holds until the next op completes.
- busy_out  output  1  high while a multiply is in progress.
- done_out  output  1  one-cycle pulse when q_out is updated.

Behaviour:
- Reset (async, any state including mid-multiply): q_out=0, busy_out=0, done_out=0, FSM to IDLE, counter and accumulator cleared, in-flight op discarded.
- Opcodes:
  - 000 add: q = {zeros, carry, a+b}.
  - 001 sub: q = {DATA_WIDTH copies of borrow, a-b}; borrow=1 when a<b unsigned.
  - 010 mul: q = a*b unsigned, full 2*DATA_WIDTH bits.
  - 011 nand: q = {zeros, ~(a&b)}.
  - 100 nor: q = {zeros, ~(a|b)}.
  - 101 and: q = {zeros, a&b}.
  - 110 xor: q = {zeros, a^b}.
  - 111 reserved: q = 0; still completes with done_out.
- FSM states: IDLE, MUL.
- IDLE, start_in=1, non-mul opcode: on that edge q_out loads the result and done_out=1 for the following cycle; state stays IDLE. Latency is 1 edge.
- IDLE, start_in=1, sel_in=010:
  - On that edge, latch a and b, clear accumulator and counter, go to MUL, busy_out=1.
  - Each MUL edge: if multiplier bit[count] is 1, add the multiplicand shifted left by count into the accumulator; then count+1.
  - On the DATA_WIDTH-th MUL edge: q_out loads the accumulator, done_out=1, busy_out=0, return to IDLE.
  - Total latency is DATA_WIDTH+1 edges from the start edge.
- start_in while busy_out=1: ignored; operands and opcode are not re-latched; no queuing.
- A start may be accepted in the same cycle done_out is high (busy_out=0 then), giving back-to-back ops.
- a_in, b_in and sel_in may change freely after the start edge without affecting the op in flight.
- done_out never stays high for more than one cycle per accepted start.
- Counter width is $clog2(DATA_WIDTH+1).
- No combinational path from any input to any output.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- When defined, adds three outputs, each 1 bit, registered with q_out and reset to 0:
  - zero_out: next q_out == 0.
  - cout_out: carry for add, borrow for sub, (upper half of product != 0) for mul, 0 for all other ops.
  - illegal_out: 1 for opcode 111.
- These outputs update only when done_out pulses.
- When undefined, the ports and their logic are absent; all other behaviour is identical.

Test Plan (DATA_WIDTH=8):
- Add: a=200, b=100, sel=000, start 1 cycle -> next cycle q_out=16'h012C, done_out=1 for exactly 1 cycle, busy_out stays 0.
- Sub with borrow: a=3, b=5, sel=001 -> q_out=16'hFFFE. Then a=5, b=3 -> q_out=16'h0002.
- Multiply: a=255, b=255, sel=010 -> busy_out high for 8 cycles, done_out 9 cycles after the start edge, q_out=16'hFE01. Repeat a=0, b=77 -> q_out=0.
- Busy and back-to-back:
  - Pulse start with sel=000 while a multiply is busy -> ignored; multiply result is unchanged.
  - Start an add in the done_out cycle -> accepted; result appears the next cycle.
- Logic and reserved ops, a=8'hF0, b=8'hCC:
  - nand -> 16'h003F.
  - nor -> 16'h0003.
  - xor -> 16'h003C.
  - sel=111 -> 16'h0000 with done_out=1 (illegal_out=1 when ALU_SEQ_FLAGS_EN is defined).
- Reset mid-multiply: assert rst_in 4 cycles into a multiply -> outputs 0 immediately, without waiting for a clock edge. After release, a new multiply 12*13 -> q_out=16'h009C.
